apb_multi_slave_responder: RTL and testbench
============================================

Name: apb_multi_slave_responder

Overview:
- Parametrised APB4 completer model that serves NUM_SLV one-hot-selected slaves behind the AHB-APB bridge.
- Each slave owns a DEPTH-word register file with byte-strobe writes.
- Supports programmable wait states (Pready), error responses (Pslverr) and an error counter.
- Successor to the fixed 32-bit, zero-wait APB slave side; used as a synthesisable APB endpoint for bridge bring-up and as a reference model for the APB agent.

Parameters:
- NUM_SLV, 4, number of slaves; width of Pselx.
- ADDR_W, 32, Paddr width.
- DATA_W, 32, data width; must be 8, 16 or 32.
- DEPTH, 16, words per slave; power of two, at least 2.
- WAIT_W, 4, width of the wait-state configuration.

Ports:
- Hclk, input, 1, single clock; all state updates on the rising edge.
- Hreset, input, 1, synchronous active-high reset.
- Pselx, input, NUM_SLV, one-hot slave select.
- Penable, input, 1, access-phase indicator.
- Pwrite, input, 1, 1 = write, 0 = read.
- Paddr, input, ADDR_W, byte address.
- Pwdata, input, DATA_W, write data.
- Pstrb, input, DATA_W/8, write byte strobes.
- wait_cfg, input, WAIT_W, wait cycles inserted per access; sampled at setup.
- Prdata, output, DATA_W, read data.
- Pready, output, 1, transfer-complete.
- Pslverr, output, 1, error response; valid only while Pready = 1.
- err_cnt, output, 8, saturating count of Pslverr completions.

Behaviour:
- Reset (Hreset = 1 at an edge):
  - State = IDLE; Pready, Pslverr, Prdata and err_cnt all 0; wait counter 0.
  - All register-file words cleared to 0.
  - Reset mid-access aborts the transfer with no write.
- FSM, states IDLE and ACCESS:
  - IDLE -> ACCESS when any Pselx bit = 1 and Penable = 0 (setup cycle). At that edge capture:
    - slave index, Pwrite, Pwdata, Pstrb;
    - word index = Paddr[log2(DATA_W/8) +: log2(DEPTH)];
    - err_q = (Pselx not one-hot) OR (Paddr word offset >= DEPTH);
    - cnt = wait_cfg;
    - rdata_q = mem[slave][index], or 0 when err_q = 1.
  - Penable = 1 seen in IDLE with no setup: ignored; Pready stays 0; no access.
  - ACCESS with Penable = 1 and cnt != 0: cnt decrements; Pready = 0.
  - ACCESS with cnt = 0: Pready = 1 (decoded from registered state and cnt, no input paths). The edge with Pready = 1 and Penable = 1 completes the transfer -> IDLE.
  - ACCESS with Penable still 0: treated as a repeated setup; recapture all fields and reload cnt.
  - ACCESS with the captured Pselx bit dropped: abort -> IDLE; no write; no error counted.
- Latency:
  - wait_cfg = N gives Pready in the (N+1)th Penable cycle.
  - Minimum transfer is 2 cycles (setup plus one access cycle).
  - Back-to-back transfers: setup is accepted in the cycle after completion; no idle gap is required.
- Write commit: at the completing edge, if Pwrite = 1 and err_q = 0, byte lane b of mem[slave][index] is updated where Pstrb[b] = 1. Pstrb = 0 is a legal no-op.
- Read visibility: a read whose setup follows a write to the same word returns the new data, because the write commits before the read capture.
- Outputs during and outside access:
  - Pslverr = Pready AND err_q.
  - Prdata = rdata_q while in ACCESS on a read with err_q = 0; otherwise 0.
- err_cnt increments at each completing edge with err_q = 1 and saturates at 255.
- Paddr bits above the word index and the low byte-offset bits are ignored; unaligned addresses are treated as aligned.

Decomposition:
- Package apb_bridge_pkg holds:
  - state enum (IDLE, ACCESS);
  - default parameter constants;
  - onehot check function;
  - index-width localparam helpers (clog2 of DEPTH and DATA_W/8).
- Sub-module apb_slv_regfile: one DEPTH x DATA_W register file with synchronous reset clear, a byte-strobe write port and a combinational read port. Instantiated NUM_SLV times by a generate loop; the top level muxes reads by the captured slave index.

Test Plan:
- Zero-wait write then read: wait_cfg = 0; write 0xDEADBEEF, Pstrb = 0xF to slave 2, Paddr 0x08, then read it -> each transfer takes 2 cycles; read returns 0xDEADBEEF; Pslverr = 0.
- Wait states: wait_cfg = 3; read of slave 0 -> Pready low for 3 Penable cycles, high on the 4th; Prdata = 0 after reset.
- Byte strobes: write 0x11223344, Pstrb = 0xF; then write 0xAABBCCDD, Pstrb = 0x5, to the same word -> readback 0x11BB33DD.
- Errors: Paddr 0x40 with DEPTH = 16 (word 16), and Pselx = 0x3 -> both complete with Pslverr = 1; no memory change; Prdata = 0; err_cnt = 2. Then 300 error transfers -> err_cnt = 255.
- Back-to-back and abort: write then immediate read of the same address -> new data returned. Drop Pselx during wait state (wait_cfg = 5) -> no write, FSM in IDLE, next transfer normal.
- Reset mid-access: assert Hreset during a wait state -> next cycle Pready = 0, all memory reads 0, err_cnt = 0.

Source files
------------

// File: rtl/apb_multi_slave_responder_pkg.sv
// Shared types, default parameters and index-width helpers for the APB
// multi-slave responder and its register files.
package apb_bridge_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned DEF_NUM_SLV = 32'd4;
    localparam int unsigned DEF_ADDR_W  = 32'd32;
    localparam int unsigned DEF_DATA_W  = 32'd32;
    localparam int unsigned DEF_DEPTH   = 32'd16;
    localparam int unsigned DEF_WAIT_W  = 32'd4;

    // Bits needed to address one word of a DEPTH-deep file.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Byte-offset bits below the word index.
    function automatic int unsigned off_width(input int unsigned data_w);
        return $clog2(data_w / 32'd8);
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/apb_multi_slave_responder_if.sv
// APB bus bundle between the requester (master) and the responder (slave).
interface apb_multi_slave_responder_if #(
    parameter int unsigned NUM_SLV = 32'd4,
    parameter int unsigned ADDR_W  = 32'd32,
    parameter int unsigned DATA_W  = 32'd32
);
    logic [NUM_SLV-1:0]    Pselx;
    logic                  Penable;
    logic                  Pwrite;
    logic [ADDR_W-1:0]     Paddr;
    logic [DATA_W-1:0]     Pwdata;
    logic [DATA_W/8-1:0]   Pstrb;
    logic [DATA_W-1:0]     Prdata;
    logic                  Pready;
    logic                  Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_multi_slave_responder_regfile.sv
// One DEPTH x DATA_W register file: synchronous clear, byte-strobe write,
// combinational read.
module apb_slv_regfile
    import apb_bridge_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned IDX_W  = idx_width(DEPTH),
    localparam int unsigned STRB_W = DATA_W / 32'd8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] strb_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage: cleared on reset, byte lanes updated where the strobe is set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                mem_q[w] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_multi_slave_responder.sv
// APB4 completer serving NUM_SLV one-hot-selected register files with
// programmable wait states, error responses and a saturating error counter.
module apb_multi_slave_responder
    import apb_bridge_pkg::*;
#(
    parameter int unsigned NUM_SLV = DEF_NUM_SLV,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned WAIT_W  = DEF_WAIT_W
) (
    input  logic                        Hclk,
    input  logic                        Hreset,
    apb_multi_slave_responder_if.slave  apb,
    input  logic [WAIT_W-1:0]           wait_cfg,
    output logic [7:0]                  err_cnt
);

    localparam int unsigned IDX_W  = idx_width(DEPTH);
    localparam int unsigned OFF_W  = off_width(DATA_W);
    localparam int unsigned STRB_W = DATA_W / 32'd8;
    localparam int unsigned SLV_W  = (NUM_SLV > 32'd1) ? $clog2(NUM_SLV) : 32'd1;

    apb_state_e          state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [SLV_W-1:0]    slv_q, slv_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [SLV_W-1:0]    setup_slv_s;
    logic [ADDR_W-1:0]   word_off_s;
    logic [IDX_W-1:0]    setup_idx_s;
    logic                setup_err_s;
    logic                setup_s;
    logic                sel_kept_s;
    logic                capture_s;
    logic                commit_s;
    logic [DATA_W-1:0]   rf_rdata_s [NUM_SLV];
    logic [NUM_SLV-1:0]  rf_we_s;

    assign word_off_s  = apb.Paddr >> OFF_W;
    assign setup_idx_s = word_off_s[IDX_W-1:0];
    assign setup_err_s = !is_onehot(32'(apb.Pselx)) ||
                         ((word_off_s >> IDX_W) != {ADDR_W{1'b0}});
    assign setup_s     = (|apb.Pselx) && !apb.Penable;
    assign sel_kept_s  = apb.Pselx[slv_q];

    // Lowest selected slave wins when the select is not one-hot.
    always_comb begin
        setup_slv_s = {SLV_W{1'b0}};
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if (apb.Pselx[i]) begin
                setup_slv_s = SLV_W'(i);
            end else begin
                setup_slv_s = setup_slv_s;
            end
        end
    end

    // Next-state logic: setup capture, wait countdown, completion and abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        slv_d     = slv_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        capture_s = 1'b0;
        commit_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    capture_s = 1'b1;
                    state_d   = ACCESS;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACCESS: begin
                if (!sel_kept_s) begin
                    state_d = IDLE;
                end else if (!apb.Penable) begin
                    capture_s = 1'b1;
                end else if (cnt_q != {WAIT_W{1'b0}}) begin
                    cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d  = IDLE;
                    commit_s = 1'b1;
                    if (err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_s) begin
            slv_d   = setup_slv_s;
            wr_d    = apb.Pwrite;
            wdata_d = apb.Pwdata;
            strb_d  = apb.Pstrb;
            idx_d   = setup_idx_s;
            err_d   = setup_err_s;
            cnt_d   = wait_cfg;
            rdata_d = setup_err_s ? {DATA_W{1'b0}} : rf_rdata_s[setup_slv_s];
        end else begin
            slv_d   = slv_d;
        end
    end

    // State and captured-transfer registers.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= IDLE;
            cnt_q     <= {WAIT_W{1'b0}};
            err_q     <= 1'b0;
            slv_q     <= {SLV_W{1'b0}};
            wr_q      <= 1'b0;
            wdata_q   <= {DATA_W{1'b0}};
            strb_q    <= {STRB_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            slv_q     <= slv_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_SLV); g++) begin : g_slv
        assign rf_we_s[g] = commit_s && wr_q && !err_q && (slv_q == SLV_W'(g));

        apb_slv_regfile #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_rf (
            .clk_i   (Hclk),
            .rst_i   (Hreset),
            .we_i    (rf_we_s[g]),
            .waddr_i (idx_q),
            .wdata_i (wdata_q),
            .strb_i  (strb_q),
            .raddr_i (setup_idx_s),
            .rdata_o (rf_rdata_s[g])
        );
    end

    // Outputs decode only registered state, so there is no input-to-output path.
    assign apb.Pready  = (state_q == ACCESS) && (cnt_q == {WAIT_W{1'b0}});
    assign apb.Pslverr = apb.Pready && err_q;
    assign apb.Prdata  = ((state_q == ACCESS) && !wr_q && !err_q) ? rdata_q : {DATA_W{1'b0}};
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_multi_slave_responder.sv
// Directed bench for apb_multi_slave_responder with hand-computed expectations.
module tb_apb_multi_slave_responder;

    logic       Hclk = 1'b0;
    logic       Hreset;
    logic [3:0] wait_cfg;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    apb_multi_slave_responder_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_multi_slave_responder #(
        .NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_W(4)
    ) dut (
        .Hclk     (Hclk),
        .Hreset   (Hreset),
        .apb      (bus),
        .wait_cfg (wait_cfg),
        .err_cnt  (err_cnt)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one transfer starting now (1 time unit after an edge) and returns
    // 1 time unit after its completing edge with the bus released.
    task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] wt,
                        output logic [31:0] rdata, output logic slverr,
                        output int cycles, output int waitlow);
        logic done;
        done    = 1'b0;
        cycles  = 1;
        waitlow = 0;
        rdata   = 32'd0;
        slverr  = 1'b0;
        bus.Pselx   = sel;
        bus.Penable = 1'b0;
        bus.Pwrite  = wr;
        bus.Paddr   = addr;
        bus.Pwdata  = wdata;
        bus.Pstrb   = strb;
        wait_cfg    = wt;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            cycles++;
            if (bus.Pready) begin
                rdata  = bus.Prdata;
                slverr = bus.Pslverr;
                done   = 1'b1;
            end else begin
                waitlow++;
            end
            @(posedge Hclk); #1;
        end
        bus.Pselx   = 4'b0000;
        bus.Penable = 1'b0;
        check("xfer_done", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] rd;
    logic        se;
    int          cyc;
    int          wl;

    initial begin
        Hreset      = 1'b1;
        wait_cfg    = 4'd0;
        bus.Pselx   = 4'b0000;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = 32'd0;
        bus.Pwdata  = 32'd0;
        bus.Pstrb   = 4'h0;
        repeat (2) @(posedge Hclk);
        #1;
        check("rst_pready",  {31'd0, bus.Pready},  32'd0);
        check("rst_pslverr", {31'd0, bus.Pslverr}, 32'd0);
        check("rst_prdata",  bus.Prdata,           32'd0);
        check("rst_errcnt",  {24'd0, err_cnt},     32'd0);
        Hreset = 1'b0;

        // Penable without a preceding setup must not start an access.
        bus.Pselx   = 4'b0100;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
        check("no_setup_pready", {31'd0, bus.Pready}, 32'd0);
        @(posedge Hclk); #1;
        check("no_setup_pready2", {31'd0, bus.Pready}, 32'd0);
        bus.Pselx   = 4'b0000;
        bus.Penable = 1'b0;
        @(posedge Hclk); #1;

        // Zero-wait write then read, slave 2 word 2.
        xfer(4'b0100, 32'h08, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, rd, se, cyc, wl);
        check("zw_wr_cycles", cyc, 32'd2);
        check("zw_wr_slverr", {31'd0, se}, 32'd0);
        xfer(4'b0100, 32'h08, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("zw_rd_cycles", cyc, 32'd2);
        check("zw_rd_data", rd, 32'hDEADBEEF);
        check("zw_rd_slverr", {31'd0, se}, 32'd0);

        // Three wait states on a read of an untouched word.
        xfer(4'b0001, 32'h00, 1'b0, 32'h0, 4'h0, 4'd3, rd, se, cyc, wl);
        check("ws_waitlow", wl, 32'd3);
        check("ws_cycles", cyc, 32'd5);
        check("ws_data", rd, 32'h0);

        // Byte strobes on slave 1 word 3.
        xfer(4'b0010, 32'h0C, 1'b1, 32'h11223344, 4'hF, 4'd0, rd, se, cyc, wl);
        xfer(4'b0010, 32'h0C, 1'b1, 32'hAABBCCDD, 4'h5, 4'd0, rd, se, cyc, wl);
        xfer(4'b0010, 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("strb_data", rd, 32'h11BB33DD);

        // Out-of-range word and multi-hot select both error without writing.
        xfer(4'b0010, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 4'd0, rd, se, cyc, wl);
        check("err_range_slverr", {31'd0, se}, 32'd1);
        xfer(4'b0011, 32'h0C, 1'b1, 32'hFFFFFFFF, 4'hF, 4'd1, rd, se, cyc, wl);
        check("err_multi_slverr", {31'd0, se}, 32'd1);
        check("err_multi_cycles", cyc, 32'd3);
        check("err_cnt_2", {24'd0, err_cnt}, 32'd2);
        xfer(4'b0010, 32'h00, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("err_nowrite_s1w0", rd, 32'h0);
        xfer(4'b0001, 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("err_nowrite_s0w3", rd, 32'h0);
        xfer(4'b0010, 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("err_nowrite_s1w3", rd, 32'h11BB33DD);
        xfer(4'b0100, 32'h48, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("err_rd_data", rd, 32'h0);
        check("err_rd_slverr", {31'd0, se}, 32'd1);
        check("err_cnt_3", {24'd0, err_cnt}, 32'd3);
        for (int k = 0; k < 300; k++) begin
            xfer(4'b1000, 32'h100, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        end
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // Back-to-back write then read, and a zero-strobe write.
        xfer(4'b1000, 32'h14, 1'b1, 32'hCAFEF00D, 4'hF, 4'd0, rd, se, cyc, wl);
        xfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("b2b_data", rd, 32'hCAFEF00D);
        xfer(4'b1000, 32'h14, 1'b1, 32'h00000000, 4'h0, 4'd0, rd, se, cyc, wl);
        xfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("strb0_data", rd, 32'hCAFEF00D);

        // Abort by dropping select during wait states.
        bus.Pselx   = 4'b1000;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h14;
        bus.Pwdata  = 32'h12345678;
        bus.Pstrb   = 4'hF;
        wait_cfg    = 4'd5;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
        check("abort_wait_pready", {31'd0, bus.Pready}, 32'd0);
        @(posedge Hclk); #1;
        bus.Pselx   = 4'b0000;
        bus.Penable = 1'b0;
        @(posedge Hclk); #1;
        check("abort_pready", {31'd0, bus.Pready}, 32'd0);
        xfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("abort_nowrite", rd, 32'hCAFEF00D);
        check("abort_next_cycles", cyc, 32'd2);
        check("abort_errcnt", {24'd0, err_cnt}, 32'd255);

        // Reset in the middle of a wait state.
        bus.Pselx   = 4'b0001;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h00;
        bus.Pwdata  = 32'h55AA55AA;
        bus.Pstrb   = 4'hF;
        wait_cfg    = 4'd4;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        @(posedge Hclk); #1;
        check("mrst_pready", {31'd0, bus.Pready}, 32'd0);
        check("mrst_errcnt", {24'd0, err_cnt}, 32'd0);
        Hreset      = 1'b0;
        bus.Pselx   = 4'b0000;
        bus.Penable = 1'b0;
        @(posedge Hclk); #1;
        xfer(4'b0100, 32'h08, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("mrst_s2w2", rd, 32'h0);
        xfer(4'b0010, 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("mrst_s1w3", rd, 32'h0);
        xfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("mrst_s3w5", rd, 32'h0);
        xfer(4'b0001, 32'h00, 1'b0, 32'h0, 4'h0, 4'd0, rd, se, cyc, wl);
        check("mrst_s0w0", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
